// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter
// Shares one single-port memory between the instruction-fetch port (IF) and
// the Execute-stage data port (DM). Each access is granted in IDLE; writes
// finish in the grant cycle, reads wait MEM_LAT cycles in RD_WAIT and return
// a one-cycle rvalid pulse to the owner.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   if_req/if_addr        fetch read request (level-held until if_gnt)
//   if_gnt                fetch accepted this cycle
//   if_rvalid/if_rdata    fetch data return
//   dm_req/dm_we/dm_addr/dm_wdata  data request (level-held until dm_gnt)
//   dm_gnt                data access accepted this cycle
//   dm_rvalid/dm_rdata    load data return
//   flush                 pipeline flush; blocks IF grants, kills in-flight fetch data
//   halt                  CPU halted; no new grants
//   mem_en/mem_we/mem_addr/mem_wdata  memory command, driven in the grant cycle
//   mem_rdata             memory read data, valid MEM_LAT cycles after a read
//   busy                  a read is outstanding
module pipeline_mem_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              flush,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned LAT_W = 2;
    localparam int unsigned STV_W = 4;
    localparam logic [STV_W-1:0] STV_SAT = '1;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t            state_q;
    logic [LAT_W-1:0]  lat_q;
    logic              owner_if_q;
    logic              stale_q;
    logic [STV_W-1:0]  starve_q;
    logic              if_rv_q;
    logic              dm_rv_q;
    logic [DATA_W-1:0] if_stage_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic              gnt_if_c;
    logic              gnt_dm_c;
    logic              if_rv_c;

    // Arbitration: DM first, IF when DM is idle or IF has been starved.
    always_comb begin
        gnt_if_c = 1'b0;
        gnt_dm_c = 1'b0;
        if (rst_n && (state_q == IDLE) && !halt) begin
            if (if_req && !flush && (!dm_req || (starve_q >= STV_W'(STARVE_MAX)))) begin
                gnt_if_c = 1'b1;
            end else if (dm_req) begin
                gnt_dm_c = 1'b1;
            end
        end
    end

    // Memory command follows the winner in the grant cycle.
    always_comb begin
        mem_en    = gnt_if_c | gnt_dm_c;
        mem_we    = gnt_dm_c & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_if_c) begin
            mem_addr = if_addr;
        end else if (gnt_dm_c) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    // A flush arriving in the rvalid cycle itself still kills the fetch
    // response, so the pulse and the visible data are gated here.
    assign if_rv_c   = if_rv_q & ~flush;
    assign if_gnt    = gnt_if_c;
    assign dm_gnt    = gnt_dm_c;
    assign if_rvalid = if_rv_c;
    assign if_rdata  = if_rv_c ? if_stage_q : if_rdata_q;
    assign dm_rvalid = dm_rv_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = (state_q == RD_WAIT);

    // Access sequencing, starvation tracking and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            owner_if_q <= 1'b0;
            stale_q    <= 1'b0;
            starve_q   <= '0;
            if_rv_q    <= 1'b0;
            dm_rv_q    <= 1'b0;
            if_stage_q <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if_rv_q <= 1'b0;
            dm_rv_q <= 1'b0;

            // Fetch data becomes the held value only once it is actually delivered.
            if (if_rv_c) begin
                if_rdata_q <= if_stage_q;
            end

            if (gnt_if_c) begin
                starve_q <= '0;
            end else if (gnt_dm_c && if_req && !flush && (starve_q != STV_SAT)) begin
                starve_q <= starve_q + STV_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (gnt_if_c || (gnt_dm_c && !dm_we)) begin
                        state_q    <= RD_WAIT;
                        lat_q      <= LAT_W'(MEM_LAT - 1);
                        owner_if_q <= gnt_if_c;
                        stale_q    <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (lat_q == '0) begin
                        state_q <= IDLE;
                        if (owner_if_q) begin
                            if (!stale_q && !flush) begin
                                if_stage_q <= mem_rdata;
                                if_rv_q    <= 1'b1;
                            end
                        end else begin
                            dm_rdata_q <= mem_rdata;
                            dm_rv_q    <= 1'b1;
                        end
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                        if (owner_if_q && flush) begin
                            stale_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Testbench for pipeline_mem_arbiter: directed scenarios plus random traffic,
// checked by a scoreboard fed from a transaction-level reference model.
module tb_pipeline_mem_arbiter;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 8;
    localparam int unsigned LAT  = 3;
    localparam int unsigned SMAX = 4;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          flush;
    logic          halt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    pipeline_mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_LAT   (LAT),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .flush    (flush),
        .halt     (halt),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory environment ----------------
    logic [7:0]  env_mem [0:4095];
    int          pend;
    logic [15:0] raddr;
    logic [7:0]  junk;

    // Read data is only valid in the single cycle MEM_LAT after the read.
    assign mem_rdata = (pend == 1) ? env_mem[raddr[11:0]] : junk;

    always @(posedge clk) begin
        junk <= 8'($urandom);
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) env_mem[i] <= 8'(i * 7 + 3);
            env_mem[16'h0010] <= 8'hA5;
            pend  <= 0;
            raddr <= '0;
        end else begin
            if (mem_en && mem_we) env_mem[mem_addr[11:0]] <= mem_wdata;
            if (mem_en && !mem_we) begin
                pend  <= LAT;
                raddr <= mem_addr;
            end else if (pend != 0) begin
                pend <= pend - 1;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        bit         is_if;
        logic [7:0] data;
        int         gcyc;
        int         due;
    } resp_t;

    typedef struct {
        int          cyc;
        bit          gi;
        bit          gd;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wd;
        bit          bsy;
    } gexp_t;

    resp_t      rq[$];
    gexp_t      gq[$];
    logic [7:0] m_mem [0:4095];
    int         cyc;
    int         free_at;
    int         starve;
    bit         last_gi;
    bit         last_gd;
    bit         chk_en;
    int         n_checks;
    int         n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: apply inputs, predict this cycle's behaviour, advance.
    task automatic step(input logic ir, input logic [15:0] ia, input logic dr,
                        input logic dwe, input logic [15:0] da, input logic [7:0] dwd,
                        input logic fl, input logic hl);
        gexp_t g;
        resp_t r;
        bit    idle;
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = dwe;
        dm_addr  = da;
        dm_wdata = dwd;
        flush    = fl;
        halt     = hl;

        idle = (cyc >= free_at);
        // A flush between grant and delivery cancels the pending fetch response.
        if (fl && rq.size() > 0 && rq[$].is_if && cyc > rq[$].gcyc && cyc <= rq[$].due)
            void'(rq.pop_back());

        g.gi = 1'b0;
        g.gd = 1'b0;
        if (idle && !hl) begin
            if (ir && !fl && (!dr || starve >= int'(SMAX))) g.gi = 1'b1;
            else if (dr) g.gd = 1'b1;
        end
        g.cyc  = cyc;
        g.bsy  = !idle;
        g.we   = g.gd && dwe;
        g.addr = g.gi ? ia : da;
        g.wd   = dwd;

        if (g.gi) starve = 0;
        else if (g.gd && ir && !fl && starve < 15) starve = starve + 1;

        if (g.gd && dwe) begin
            m_mem[da[11:0]] = dwd;
        end else if (g.gi || g.gd) begin
            r.is_if = g.gi;
            r.data  = m_mem[g.addr[11:0]];
            r.gcyc  = cyc;
            r.due   = cyc + int'(LAT) + 1;
            rq.push_back(r);
            free_at = cyc + int'(LAT) + 1;
        end
        gq.push_back(g);
        last_gi = g.gi;
        last_gd = g.gd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        repeat (n) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every observed cycle against the queued predictions.
    gexp_t      mg;
    resp_t      mr;
    bit         exp_ifv;
    bit         exp_dmv;
    logic [7:0] last_if;
    logic [7:0] last_dm;

    always @(negedge clk) begin
        if (chk_en) begin
            if (gq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL grant_queue_empty @cycle %0d: got none expected one entry", cyc);
            end else begin
                mg = gq.pop_front();
                chk("grant", 32'({if_gnt, dm_gnt}), 32'({mg.gi, mg.gd}));
                chk("mem_en", 32'(mem_en), 32'(mg.gi | mg.gd));
                if (mg.gi || mg.gd) begin
                    chk("mem_addr", 32'(mem_addr), 32'(mg.addr));
                    chk("mem_we", 32'(mem_we), 32'(mg.we));
                    if (mg.we) chk("mem_wdata", 32'(mem_wdata), 32'(mg.wd));
                end
                chk("busy", 32'(busy), 32'(mg.bsy));
                exp_ifv = 1'b0;
                exp_dmv = 1'b0;
                while (rq.size() > 0 && rq[0].due < mg.cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_overdue @cycle %0d: got nothing expected due %0d", mg.cyc, rq[0].due);
                    void'(rq.pop_front());
                end
                if (rq.size() > 0 && rq[0].due == mg.cyc) begin
                    mr = rq.pop_front();
                    if (mr.is_if) begin
                        exp_ifv = 1'b1;
                        last_if = mr.data;
                    end else begin
                        exp_dmv = 1'b1;
                        last_dm = mr.data;
                    end
                end
                chk("if_rvalid", 32'(if_rvalid), 32'(exp_ifv));
                chk("dm_rvalid", 32'(dm_rvalid), 32'(exp_dmv));
                chk("if_rdata", 32'(if_rdata), 32'(last_if));
                chk("dm_rdata", 32'(dm_rdata), 32'(last_dm));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic        p_if, p_dm, p_we, fl, hl;
    logic [15:0] p_ia, p_da;
    logic [7:0]  p_wd;
    int          hold_h;
    int          ndm;
    int          ng;
    bit          got_if;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        free_at  = 0;
        starve   = 0;
        chk_en   = 1'b0;
        last_if  = 8'h00;
        last_dm  = 8'h00;
        for (int i = 0; i < 4096; i++) m_mem[i] = 8'(i * 7 + 3);
        m_mem[16'h0010] = 8'hA5;

        rst_n    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 16'h0010;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 16'h0200;
        dm_wdata = 8'h00;
        flush    = 1'b0;
        halt     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_gnt", 32'(if_gnt), 32'(0));
        chk("rst_dm_gnt", 32'(dm_gnt), 32'(0));
        chk("rst_if_rvalid", 32'(if_rvalid), 32'(0));
        chk("rst_dm_rvalid", 32'(dm_rvalid), 32'(0));
        chk("rst_if_rdata", 32'(if_rdata), 32'(0));
        chk("rst_dm_rdata", 32'(dm_rdata), 32'(0));
        chk("rst_mem_en", 32'(mem_en), 32'(0));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // DM store wins first, then the fetch of 0x0010 returns 0xA5.
        step(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0200, 8'h3C, 1'b0, 1'b0);
        step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        idle_steps(LAT + 1);

        // Clear starvation with a fetch, then contend with back-to-back stores.
        step(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        idle_steps(LAT + 1);
        ndm    = 0;
        got_if = 1'b0;
        for (int i = 0; i < 12 && !got_if; i++) begin
            step(1'b1, 16'h0011, 1'b1, 1'b1, 16'h0300 + 16'(i), 8'(i + 1), 1'b0, 1'b0);
            if (last_gd) ndm++;
            if (last_gi) got_if = 1'b1;
        end
        chk("starve_run_len", 32'(ndm), 32'(SMAX));
        chk("starve_if_won", 32'(got_if), 32'(1));
        idle_steps(LAT + 1);

        // Fetch flushed mid-flight; a following DM read of 0x0200 returns 0x3C.
        step(1'b1, 16'h0012, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        idle_steps(1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        idle_steps(1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 1'b0);
        chk("flush_dm_read_gnt", 32'(dm_gnt | last_gd), 32'(1));
        idle_steps(LAT + 1);

        // Halt while a DM read of 0x7E is outstanding.
        step(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0055, 8'h7E, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0055, 8'h00, 1'b0, 1'b0);
        ng = 0;
        repeat (6) begin
            step(1'b1, 16'h0013, 1'b1, 1'b1, 16'h0056, 8'h11, 1'b0, 1'b1);
            if (last_gi || last_gd) ng++;
        end
        chk("halt_no_grant", 32'(ng), 32'(0));
        step(1'b1, 16'h0013, 1'b1, 1'b1, 16'h0056, 8'h11, 1'b0, 1'b0);
        chk("halt_resume", 32'(last_gi | last_gd), 32'(1));
        idle_steps(LAT + 1);

        // Randomized traffic with level-held requests.
        p_if   = 1'b0;
        p_dm   = 1'b0;
        p_we   = 1'b0;
        p_ia   = '0;
        p_da   = '0;
        p_wd   = '0;
        hold_h = 0;
        for (int k = 0; k < 800; k++) begin
            if (!p_if && $urandom_range(0, 2) == 0) begin
                p_if = 1'b1;
                p_ia = 16'($urandom_range(0, 63));
            end
            if (!p_dm && $urandom_range(0, 1) == 0) begin
                p_dm = 1'b1;
                p_we = 1'($urandom_range(0, 1));
                p_da = 16'($urandom_range(0, 63));
                p_wd = 8'($urandom);
            end
            fl = ($urandom_range(0, 7) == 0);
            if (hold_h > 0) hold_h--;
            else if ($urandom_range(0, 19) == 0) hold_h = $urandom_range(1, 6);
            hl = (hold_h > 0);
            step(p_if, p_ia, p_dm, p_we, p_da, p_wd, fl, hl);
            if (last_gi) p_if = 1'b0;
            if (last_gd) p_dm = 1'b0;
        end
        idle_steps(LAT + 2);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
